// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port shared by the fetch stage and the memory.
//   req   : fetch request, held high until ack
//   addr  : word address of the request, stable while req is high
//   rdata : instruction word, valid in the ack cycle
//   ack   : one-cycle read-complete strobe
// master = fetch unit, slave = instruction memory.
interface instr_fetch_unit_if #(
  parameter int PC_W = 32
);
  logic            req;
  logic [PC_W-1:0] addr;
  logic [31:0]     rdata;
  logic            ack;

  modport master (
    output req,
    output addr,
    input  rdata,
    input  ack
  );

  modport slave (
    input  req,
    input  addr,
    output rdata,
    output ack
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Program counter and instruction fetch stage of the MIPS core.
// Fetches one word per instruction over the imem req/ack port, holds it for
// the decoder, and advances the PC when the datapath retires the instruction.
// Ports:
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   pc_src       : next-PC select (11 PC+1, 01 jump, 10 rs, 00 branch)
//   rs_data      : register rs value, JR/JALR target
//   retire       : held instruction completes this cycle
//   imem         : instruction-memory port (master side)
//   instr        : held instruction word
//   opcode/funct : instr[31:26] / instr[5:0]
//   instr_valid  : instr, opcode, funct and pc are valid for execution
//   pc, pc_plus1 : address of the held instruction and its successor
module instr_fetch_unit #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          pc_src,
  input  logic [31:0]         rs_data,
  input  logic                retire,
  instr_fetch_unit_if.master  imem,
  output logic [31:0]         instr,
  output logic [5:0]          opcode,
  output logic [5:0]          funct,
  output logic                instr_valid,
  output logic [PC_W-1:0]     pc,
  output logic [PC_W-1:0]     pc_plus1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [31:0]     instr_reg, instr_next;
  logic            valid_reg, valid_next;
  logic            req_reg, req_next;
  logic [PC_W-1:0] addr_reg, addr_next;
  logic [PC_W-1:0] target_pc;

  assign pc_plus1 = pc_reg + 1'b1;

  // Branch offset is taken relative to the successor, as in MIPS.
  always_comb begin
    target_pc = pc_plus1;
    case (pc_src)
      2'b11:   target_pc = pc_plus1;
      2'b01:   target_pc = {pc_plus1[PC_W-1:26], instr_reg[25:0]};
      2'b10:   target_pc = rs_data[PC_W-1:0];
      default: target_pc = pc_plus1 + {{(PC_W-16){instr_reg[15]}}, instr_reg[15:0]};
    endcase
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    valid_next = valid_reg;
    req_next   = req_reg;
    addr_next  = addr_reg;
    case (state_reg)
      IDLE: begin
        state_next = FETCH;
        req_next   = 1'b1;
        addr_next  = pc_reg;
      end
      FETCH: begin
        // req/addr stay as registered until the ack arrives.
        if (imem.ack) begin
          state_next = HOLD;
          instr_next = imem.rdata;
          req_next   = 1'b0;
          valid_next = 1'b1;
        end
      end
      HOLD: begin
        // Acks are ignored here; pc_src/rs_data only matter on retire.
        if (retire && valid_reg) begin
          state_next = FETCH;
          pc_next    = target_pc;
          valid_next = 1'b0;
          req_next   = 1'b1;
          addr_next  = target_pc;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      instr_reg <= '0;
      valid_reg <= 1'b0;
      req_reg   <= 1'b0;
      addr_reg  <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      valid_reg <= valid_next;
      req_reg   <= req_next;
      addr_reg  <= addr_next;
    end
  end

  assign imem.req    = req_reg;
  assign imem.addr   = addr_reg;
  assign instr       = instr_reg;
  assign opcode      = instr_reg[31:26];
  assign funct       = instr_reg[5:0];
  assign instr_valid = valid_reg;
  assign pc          = pc_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed cases plus randomized
// fetch/retire loops checked against a behavioural next-PC model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [1:0]  pc_src;
  logic [31:0] rs_data;
  logic        retire;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus1;

  instr_fetch_unit_if #(.PC_W(32)) imem ();

  instr_fetch_unit #(.PC_W(32), .RESET_PC(32'd0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_src      (pc_src),
    .rs_data     (rs_data),
    .retire      (retire),
    .imem        (imem),
    .instr       (instr),
    .opcode      (opcode),
    .funct       (funct),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus1    (pc_plus1)
  );

  always #5 clk = ~clk;

  int          total_cnt = 0;
  int          bad_cnt   = 0;
  logic [31:0] exp_pc;
  logic [31:0] cur_word;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference next-PC rule, plain 32-bit arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] cpc, input logic [31:0] w,
                                             input logic [1:0] src, input logic [31:0] rs);
    logic [31:0] off;
    case (src)
      2'b11:   return cpc + 32'd1;
      2'b01:   return ((cpc + 32'd1) & 32'hFC00_0000) | (w & 32'h03FF_FFFF);
      2'b10:   return rs;
      default: begin
        off = w & 32'h0000_FFFF;
        if (off >= 32'h0000_8000) off = off - 32'h0001_0000;
        return cpc + 32'd1 + off;
      end
    endcase
  endfunction

  // Acts as instruction memory: waits for req, stalls 'waits' cycles, acks 'word'.
  task automatic do_fetch(input logic [31:0] word, input int waits);
    int n = 0;
    while (imem.req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("req_up", {31'd0, imem.req}, 32'd1);
    check_val("req_addr", imem.addr, exp_pc);
    check_val("valid_low_fetch", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < waits; i++) begin
      retire  = 1'($urandom_range(0, 1));   // must be ignored while not valid
      pc_src  = 2'($urandom);
      rs_data = $urandom;
      @(negedge clk);
      check_val("req_wait", {31'd0, imem.req}, 32'd1);
      check_val("addr_stable", imem.addr, exp_pc);
      check_val("valid_low_wait", {31'd0, instr_valid}, 32'd0);
    end
    imem.ack   = 1'b1;
    imem.rdata = word;
    retire     = 1'($urandom_range(0, 1));
    @(negedge clk);
    imem.ack   = 1'b0;
    imem.rdata = $urandom;
    retire     = 1'b0;
    cur_word   = word;
    check_val("req_drop", {31'd0, imem.req}, 32'd0);
    check_val("valid_up", {31'd0, instr_valid}, 32'd1);
    check_val("instr", instr, word);
    check_val("opcode", {26'd0, opcode}, (word >> 26) & 32'h3F);
    check_val("funct", {26'd0, funct}, word & 32'h3F);
    check_val("pc", pc, exp_pc);
    check_val("pc_plus1", pc_plus1, exp_pc + 32'd1);
    $display("fetch addr=0x%08h word=0x%08h waits=%0d", exp_pc, word, waits);
  endtask

  // Holds for 'hold' cycles (optionally with a stray ack), then retires.
  task automatic do_retire(input logic [1:0] src, input logic [31:0] rs, input int hold, input bit stray);
    logic [31:0] nxt;
    for (int i = 0; i < hold; i++) begin
      if (stray && i == 0) begin
        imem.ack   = 1'b1;
        imem.rdata = ~cur_word;
      end
      retire  = 1'b0;
      pc_src  = 2'($urandom);
      rs_data = $urandom;
      @(negedge clk);
      imem.ack = 1'b0;
      check_val("hold_instr", instr, cur_word);
      check_val("hold_valid", {31'd0, instr_valid}, 32'd1);
      check_val("hold_pc", pc, exp_pc);
      check_val("hold_req", {31'd0, imem.req}, 32'd0);
    end
    nxt     = model_next(exp_pc, cur_word, src, rs);
    pc_src  = src;
    rs_data = rs;
    retire  = 1'b1;
    @(negedge clk);
    retire  = 1'b0;
    pc_src  = 2'($urandom);
    check_val("ret_valid", {31'd0, instr_valid}, 32'd0);
    check_val("ret_req", {31'd0, imem.req}, 32'd1);
    check_val("ret_addr", imem.addr, nxt);
    check_val("ret_pc", pc, nxt);
    $display("retire pc=0x%08h src=%0d rs=0x%08h next=0x%08h", exp_pc, src, rs, nxt);
    exp_pc = nxt;
  endtask

  initial begin
    clk        = 1'b0;
    rst_n      = 1'b0;
    pc_src     = 2'b11;
    rs_data    = '0;
    retire     = 1'b0;
    imem.ack   = 1'b0;
    imem.rdata = '0;
    exp_pc     = '0;
    cur_word   = '0;

    // Reset state, including an ack arriving while reset is held.
    @(negedge clk);
    imem.ack = 1'b1;
    imem.rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem.ack = 1'b0;
    check_val("rst_req", {31'd0, imem.req}, 32'd0);
    check_val("rst_addr", imem.addr, 32'd0);
    check_val("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_val("rst_instr", instr, 32'd0);
    check_val("rst_pc", pc, 32'd0);
    check_val("rst_opcode", {26'd0, opcode}, 32'd0);
    check_val("rst_funct", {26'd0, funct}, 32'd0);

    rst_n = 1'b1;
    @(negedge clk);
    check_val("c1_req", {31'd0, imem.req}, 32'd1);
    check_val("c1_addr", imem.addr, 32'd0);

    // Directed cases.
    do_fetch(32'h0022_1820, 3);
    do_retire(2'b11, 32'd0, 2, 1'b1);          // sequential -> 1
    do_fetch(32'h1234_5678, 1);
    do_retire(2'b10, 32'd5, 0, 1'b0);          // JR -> 5
    do_fetch(32'h0800_0010, 0);
    do_retire(2'b01, 32'd0, 1, 1'b0);          // jump -> 0x10
    do_fetch(32'h0000_0008, 2);
    do_retire(2'b10, 32'h40, 0, 1'b0);         // JR -> 0x40
    do_fetch(32'h0000_0008, 0);
    do_retire(2'b10, 32'd8, 0, 1'b0);          // JR -> 8
    do_fetch(32'h1000_FFFE, 1);
    do_retire(2'b00, 32'd0, 1, 1'b1);          // branch -2 -> 7
    do_fetch(32'h0000_0008, 0);
    do_retire(2'b10, 32'hFFFF_FFFF, 0, 1'b0);  // JR -> top of space
    do_fetch(32'h2108_0001, 0);
    do_retire(2'b11, 32'd0, 0, 1'b0);          // wrap -> 0

    // Randomized loop.
    for (int k = 0; k < 60; k++) begin
      do_fetch($urandom, int'($urandom_range(0, 3)));
      do_retire(2'($urandom), $urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset while a fetch is pending.
    #1;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_req", {31'd0, imem.req}, 32'd0);
    check_val("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    check_val("mid_rst_pc", pc, 32'd0);
    @(negedge clk);
    imem.ack   = 1'b1;
    imem.rdata = 32'hCAFE_F00D;
    @(negedge clk);
    imem.ack = 1'b0;
    check_val("mid_rst_instr", instr, 32'd0);
    check_val("mid_rst_req2", {31'd0, imem.req}, 32'd0);
    rst_n  = 1'b1;
    exp_pc = 32'd0;
    @(negedge clk);
    check_val("post_rst_req", {31'd0, imem.req}, 32'd1);
    check_val("post_rst_addr", imem.addr, 32'd0);
    do_fetch(32'h0C00_0020, 2);
    do_retire(2'b01, 32'd0, 1, 1'b1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule
